maxpool_output_packer: RTL and testbench
========================================

// Module: maxpool_output_packer
// PURPOSE
//  Sits directly downstream of the maxpool engine; consumes its valid/data/keep/last stream (no backpressure).
//  Packs max-only half beats (upper c=1 half keep=0) in pairs into dense full beats; passes full beats through.
//  Buffers in a FIFO and presents an AXI-Stream master with m_ready to the output DMA/width converter.
//  Overflow cannot be back-pressured upstream, so it is flagged sticky and the offending beat dropped.
// PARAMETERS
//  UNITS       8   units per group
//  GROUPS      2   groups per copy
//  WORD_WIDTH  8   bits per word
//  FIFO_DEPTH  16  FIFO entries, power of 2, >=4
//  Derived: W = 2*GROUPS*UNITS words/beat; H = W/2 words/half; lower half = flat bits [H*WORD_WIDTH-1:0].
// PORTS
//  clk          in   1             clock
//  resetn       in   1             async active-low reset
//  clken        in   1             clock enable; no state changes when low
//  s_valid      in   1             input beat valid (no s_ready exists)
//  s_data       in   W*WORD_WIDTH  input words, flat cgu order
//  s_keep       in   W             per-word keep
//  s_last       in   1             input packet end
//  m_valid      out  1             output beat valid
//  m_ready      in   1             output accept
//  m_data       out  W*WORD_WIDTH  packed words
//  m_keep       out  W             per-word keep
//  m_last       out  1             output packet end
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  occupied entries
//  overflow     out  1             sticky: a beat was dropped
// BEHAVIOUR
//  Reset (async, resetn=0): FIFO empty, fifo_count=0, m_valid=0, m_data/m_keep/m_last=0, overflow=0, held half cleared.
//  Beat class: HALF if s_keep == {H{0},H{1}}; otherwise FULL (keep passed through unchanged).
//  Accumulator: 1 held half (H words) + held flag.
//   HALF, none held, s_last=0: store lower half; held=1; no write.
//   HALF, none held, s_last=1: write {0, half}, keep {H{0},H{1}}, last=1.
//   HALF, held: write {new half (upper), held (lower)}, keep all 1, last=s_last; held=0.
//   FULL, none held: write beat as-is, last=s_last.
//   FULL, held: write 2 entries in one cycle: held half padded (keep lower only, last=0) then FULL beat; held=0.
//  Writes needed per beat: 0,1 or 2. Space check uses fifo_count before this cycle's read:
//   if FIFO_DEPTH-fifo_count < needed: drop whole input beat, accumulator unchanged, overflow<=1 (cleared only by reset).
//  FIFO: first-word-fall-through; m_* = head entry; m_valid = (fifo_count!=0).
//  Latency: write at edge sampling s_valid; m_valid high from that edge (1 cycle, FIFO empty).
//  Read on m_valid&&m_ready&&clken; simultaneous read+write: count += writes - read; pointers wrap mod FIFO_DEPTH.
//  Full FIFO with m_ready=1 the same cycle still drops (conservative check).
//  m_data/m_keep/m_last stable while m_valid=1 and m_ready=0.
//  clken=0: no writes, no reads, s_valid ignored, outputs hold.
// CONFIGURATION
//  MAXPOOL_PACKER_PERF_EN defined: adds outputs perf_in_beats[31:0], perf_out_beats[31:0], perf_packets[31:0],
//   perf_drops[15:0]; count accepted input beats, output handshakes, output handshakes with m_last, dropped beats;
//   reset to 0, wrap at max.
//  Undefined: ports and counters absent; other behaviour identical.
// TESTING
//  Full beats 0..9, s_last on 9, m_ready=1 -> 10 outputs, data equal, keep all 1, m_last only on 10th, latency 1.
//  Halves A,B,C,D (last on D) -> 2 outputs {B,A},{D,C}, keep all 1, m_last on 2nd only.
//  Half A with s_last=1 -> 1 output {0,A}, keep {H{0},H{1}}, m_last=1; held flag clear afterwards.
//  Half A then full F same packet -> 2 entries written in one cycle: {0,A} keep lower only, then F; fifo_count=2.
//  m_ready=0, 18 full beats with FIFO_DEPTH=16 -> 16 stored, overflow=1 at beat 17, entries 0..15 drain intact.
//  Assert resetn=0 while half held and FIFO 5 deep -> immediately m_valid=0, fifo_count=0; next half is stored, not paired.

Source files
------------

// File: rtl/maxpool_output_packer.sv
// Output packer for the maxpool engine: pairs lower-half-only beats into dense beats, buffers them
// in a first-word-fall-through FIFO. Define MAXPOOL_PACKER_PERF_EN to add the perf counter outputs.
module maxpool_output_packer #(
  parameter int UNITS      = 8,
  parameter int GROUPS     = 2,
  parameter int WORD_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int W  = 2 * GROUPS * UNITS,
  localparam int H  = W / 2,
  localparam int DW = W * WORD_WIDTH,
  localparam int HW = H * WORD_WIDTH,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clken,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic [W-1:0]  s_keep,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [W-1:0]  m_keep,
  output logic          m_last,
  output logic [CW-1:0] fifo_count,
`ifdef MAXPOOL_PACKER_PERF_EN
  output logic [31:0]   perf_in_beats,
  output logic [31:0]   perf_out_beats,
  output logic [31:0]   perf_packets,
  output logic [15:0]   perf_drops,
`endif
  output logic          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [W-1:0]  HALF_KEEP = {{H{1'b0}}, {H{1'b1}}};
  localparam logic [W-1:0]  FULL_KEEP = {W{1'b1}};
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  logic [DW-1:0] data_mem [FIFO_DEPTH];
  logic [W-1:0]  keep_mem [FIFO_DEPTH];
  logic          last_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          held_reg, held_next;
  logic [HW-1:0] held_data_reg, held_data_next;
  logic          overflow_reg;

  logic          is_half, beat_in, rd_en, drop, take;
  logic [1:0]    need, wr_cnt;
  logic [CW-1:0] space;
  logic [DW-1:0] e0_data, e1_data;
  logic [W-1:0]  e0_keep, e1_keep;
  logic          e0_last, e1_last;

  always_comb begin
    is_half        = (s_keep == HALF_KEEP);
    beat_in        = clken && s_valid;
    rd_en          = clken && m_ready && (count_reg != '0);
    need           = 2'd0;
    e0_data        = '0;
    e0_keep        = '0;
    e0_last        = 1'b0;
    e1_data        = s_data;
    e1_keep        = s_keep;
    e1_last        = s_last;
    held_next      = held_reg;
    held_data_next = held_data_reg;
    if (is_half) begin
      if (held_reg) begin
        need      = 2'd1;
        e0_data   = {s_data[HW-1:0], held_data_reg};
        e0_keep   = FULL_KEEP;
        e0_last   = s_last;
        held_next = 1'b0;
      end else if (s_last) begin
        need    = 2'd1;
        e0_data = {{HW{1'b0}}, s_data[HW-1:0]};
        e0_keep = HALF_KEEP;
        e0_last = 1'b1;
      end else begin
        held_next      = 1'b1;
        held_data_next = s_data[HW-1:0];
      end
    end else if (held_reg) begin
      // Flush the orphaned half as its own padded entry, then the full beat behind it.
      need      = 2'd2;
      e0_data   = {{HW{1'b0}}, held_data_reg};
      e0_keep   = HALF_KEEP;
      e0_last   = 1'b0;
      held_next = 1'b0;
    end else begin
      need    = 2'd1;
      e0_data = s_data;
      e0_keep = s_keep;
      e0_last = s_last;
    end
    // Space is judged before this cycle's read so a full FIFO drops even when draining.
    space      = DEPTH_C - count_reg;
    drop       = beat_in && (space < CW'(need));
    take       = beat_in && !drop;
    wr_cnt     = take ? need : 2'd0;
    count_next = count_reg + CW'(wr_cnt) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (wr_cnt != 2'd0) begin
      data_mem[wr_ptr_reg] <= e0_data;
      keep_mem[wr_ptr_reg] <= e0_keep;
      last_mem[wr_ptr_reg] <= e0_last;
    end
    if (wr_cnt == 2'd2) begin
      data_mem[wr_ptr_reg + PW'(1)] <= e1_data;
      keep_mem[wr_ptr_reg + PW'(1)] <= e1_keep;
      last_mem[wr_ptr_reg + PW'(1)] <= e1_last;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      held_reg      <= 1'b0;
      held_data_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(wr_cnt);
      rd_ptr_reg <= rd_ptr_reg + PW'(rd_en);
      count_reg  <= count_next;
      if (take) begin
        held_reg      <= held_next;
        held_data_reg <= held_data_next;
      end
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign m_valid    = (count_reg != '0);
  assign m_data     = m_valid ? data_mem[rd_ptr_reg] : '0;
  assign m_keep     = m_valid ? keep_mem[rd_ptr_reg] : '0;
  assign m_last     = m_valid ? last_mem[rd_ptr_reg] : 1'b0;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

`ifdef MAXPOOL_PACKER_PERF_EN
  logic [31:0] perf_in_reg, perf_out_reg, perf_pkt_reg;
  logic [15:0] perf_drop_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_in_reg   <= '0;
      perf_out_reg  <= '0;
      perf_pkt_reg  <= '0;
      perf_drop_reg <= '0;
    end else begin
      if (take)            perf_in_reg   <= perf_in_reg + 32'd1;
      if (rd_en)           perf_out_reg  <= perf_out_reg + 32'd1;
      if (rd_en && m_last) perf_pkt_reg  <= perf_pkt_reg + 32'd1;
      if (drop)            perf_drop_reg <= perf_drop_reg + 16'd1;
    end
  end

  assign perf_in_beats  = perf_in_reg;
  assign perf_out_beats = perf_out_reg;
  assign perf_packets   = perf_pkt_reg;
  assign perf_drops     = perf_drop_reg;
`endif

endmodule

// File: tb/tb_maxpool_output_packer.sv
// Self-checking bench for maxpool_output_packer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_maxpool_output_packer;

  localparam int DEPTH = 16;
  localparam logic [31:0] HALF_K = 32'h0000_FFFF;
  localparam logic [31:0] ALL_K  = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         resetn, clken, s_valid, s_last, m_ready;
  logic [255:0] s_data;
  logic [31:0]  s_keep;
  logic         m_valid, m_last, overflow;
  logic [255:0] m_data;
  logic [31:0]  m_keep;
  logic [4:0]   fifo_count;

  maxpool_output_packer dut (
    .clk(clk), .resetn(resetn), .clken(clken),
    .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } ent_t;

  ent_t         mq[$];
  bit           m_held;
  logic [127:0] m_hdata;
  bit           m_ovf;
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           cmp_en   = 1'b0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_held = 1'b0;
    m_hdata = '0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of the stream rules, applied to the values present at that edge.
  task automatic model_step();
    int   pre, need;
    bit   rd, half;
    ent_t a, b;
    if (!resetn || !clken) return;
    pre = mq.size();
    rd  = m_ready && (pre != 0);
    if (s_valid) begin
      half = (s_keep == HALF_K);
      a.d = '0; a.k = '0; a.l = 1'b0;
      b.d = s_data; b.k = s_keep; b.l = s_last;
      need = 1;
      if (half && m_held) begin
        a.d = {s_data[127:0], m_hdata}; a.k = ALL_K; a.l = s_last;
      end else if (half && s_last) begin
        a.d = {128'b0, s_data[127:0]}; a.k = HALF_K; a.l = 1'b1;
      end else if (half) begin
        need = 0;
      end else if (m_held) begin
        need = 2;
        a.d = {128'b0, m_hdata}; a.k = HALF_K; a.l = 1'b0;
      end else begin
        a = b;
      end
      if (DEPTH - pre < need) begin
        m_ovf = 1'b1;
      end else begin
        if (need >= 1) mq.push_back(a);
        if (need == 2) mq.push_back(b);
        if (half && !m_held && !s_last) begin
          m_held = 1'b1;
          m_hdata = s_data[127:0];
        end else begin
          m_held = 1'b0;
        end
      end
    end
    if (rd) void'(mq.pop_front());
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && resetn) begin
        chk("m_valid", m_valid, mq.size() != 0);
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, m_ovf);
        if (mq.size() != 0) begin
          chk("m_data", m_data, mq[0].d);
          chk("m_keep", m_keep, mq[0].k);
          chk("m_last", m_last, mq[0].l);
        end
      end
    end
  end

  function automatic logic [255:0] full_pat(int i);
    logic [255:0] r;
    for (int j = 0; j < 32; j++) r[j*8 +: 8] = 8'(i * 7 + j + 1);
    return r;
  endfunction

  function automatic logic [255:0] half_pat(int x);
    logic [255:0] r;
    for (int j = 0; j < 16; j++) r[j*8 +: 8] = 8'(x + j);
    for (int j = 16; j < 32; j++) r[j*8 +: 8] = 8'hAA;
    return r;
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(bit v, logic [31:0] k, logic [255:0] d, bit l);
    s_valid = v; s_keep = k; s_data = d; s_last = l;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  logic [255:0] pa, pb, pc, pd;
  int ready_pct;

  initial begin
    resetn = 1'b1; clken = 1'b1; m_ready = 1'b1;
    drive(0, '0, '0, 0);
    model_reset();
    #1 resetn = 1'b0;
    tick(); tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk) resetn = 1'b1;
    cmp_en = 1'b1;

    // Ten full beats, pass-through with one-cycle latency.
    for (int i = 0; i < 10; i++) begin
      drive(1, ALL_K, full_pat(i), i == 9);
      tick();
      chk("full_valid", m_valid, 1);
      chk("full_data", m_data, full_pat(i));
      chk("full_keep", m_keep, ALL_K);
      chk("full_last", m_last, i == 9);
    end
    drive(0, '0, '0, 0);
    tick();
    chk("full_drained", m_valid, 0);

    // Four halves pair into two dense beats.
    pa = half_pat(8'h10); pb = half_pat(8'h20); pc = half_pat(8'h30); pd = half_pat(8'h40);
    drive(1, HALF_K, pa, 0); tick();
    chk("pairA_valid", m_valid, 0);
    drive(1, HALF_K, pb, 0); tick();
    chk("pairAB_data", m_data, {pb[127:0], pa[127:0]});
    chk("pairAB_keep", m_keep, ALL_K);
    chk("pairAB_last", m_last, 0);
    drive(1, HALF_K, pc, 0); tick();
    chk("pairC_valid", m_valid, 0);
    drive(1, HALF_K, pd, 1); tick();
    chk("pairCD_data", m_data, {pd[127:0], pc[127:0]});
    chk("pairCD_last", m_last, 1);
    drive(0, '0, '0, 0); tick();

    // Lone half closing a packet goes out padded; nothing stays held.
    drive(1, HALF_K, pa, 1); tick();
    chk("lone_data", m_data, {128'b0, pa[127:0]});
    chk("lone_keep", m_keep, HALF_K);
    chk("lone_last", m_last, 1);
    drive(1, HALF_K, pb, 0); tick();
    chk("lone_not_held", m_valid, 0);
    drive(1, HALF_K, pc, 1); tick();
    chk("lone_next_pair", m_data, {pc[127:0], pb[127:0]});
    drive(0, '0, '0, 0); tick();

    // Held half followed by a full beat writes two entries at once.
    m_ready = 1'b0;
    drive(1, HALF_K, pa, 0); tick();
    drive(1, ALL_K, full_pat(50), 1); tick();
    chk("two_count", fifo_count, 2);
    chk("two_head_data", m_data, {128'b0, pa[127:0]});
    chk("two_head_keep", m_keep, HALF_K);
    chk("two_head_last", m_last, 0);
    drive(0, '0, '0, 0);
    m_ready = 1'b1; tick();
    chk("two_second_data", m_data, full_pat(50));
    chk("two_second_last", m_last, 1);
    tick();
    chk("two_empty", fifo_count, 0);

    // Overflow: 18 beats into a 16-deep FIFO that is not draining.
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(1, ALL_K, full_pat(i), 0);
      tick();
      chk("ovf_count", fifo_count, (i < 16) ? i + 1 : 16);
      chk("ovf_flag", overflow, i >= 16);
    end
    drive(0, '0, '0, 0);
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("ovf_drain", m_data, full_pat(k));
      tick();
    end
    chk("ovf_empty", m_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Asynchronous reset with a half held and five entries queued.
    m_ready = 1'b0;
    drive(1, HALF_K, pa, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, ALL_K, full_pat(60 + i), 0); tick();
    end
    drive(1, HALF_K, pb, 0); tick();
    chk("pre_rst_count", fifo_count, 5);
    drive(0, '0, '0, 0);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_overflow", overflow, 0);
    @(negedge clk) resetn = 1'b1;
    m_ready = 1'b1;
    drive(1, HALF_K, pc, 0); tick();
    chk("arst_half_stored", m_valid, 0);
    drive(1, HALF_K, pd, 1); tick();
    chk("arst_pair", m_data, {pd[127:0], pc[127:0]});
    drive(0, '0, '0, 0); tick();

    // Randomized traffic, including clock-enable gaps and overflow episodes.
    ready_pct = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) ready_pct = (c / 300 % 3 == 0) ? 90 : ((c / 300 % 3 == 1) ? 20 : 50);
      clken   = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 99) < ready_pct);
      case ($urandom_range(0, 3))
        0, 1: drive($urandom_range(0, 3) != 0, HALF_K, rand_data(), $urandom_range(0, 3) == 0);
        2:    drive($urandom_range(0, 3) != 0, ALL_K, rand_data(), $urandom_range(0, 3) == 0);
        default: drive($urandom_range(0, 3) != 0, $urandom, rand_data(), $urandom_range(0, 3) == 0);
      endcase
      tick();
    end
    clken = 1'b1;
    drive(0, '0, '0, 0);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
